// File: rtl/write_burst_scheduler.sv
// ============================================================================
// write_burst_scheduler
// ----------------------------------------------------------------------------
// Splits one video/data frame into AXI write burst requests. A frame is
// announced by an fsync pulse that carries the total beat count and the byte
// base address. The scheduler then issues bursts of NOR_BURST_LEN beats (the
// last one shorter if needed), waits for each burst to complete, and pulses
// frame_done once the whole frame has been written.
//
// An fsync that arrives while a frame is still in progress is reported on
// frame_err. If no request is outstanding, the new frame starts at once.
// Otherwise the outstanding burst is allowed to finish, and the new frame
// starts when that burst completes.
//
// Optional feature (compile-time macro):
//   WR_SCHED_FIFO_GATE_EN - when defined, a burst is only requested once the
//                           write-data FIFO holds at least a full burst
//                           (fifo_count >= len). When undefined, the request
//                           goes out the cycle after the length is computed,
//                           and fifo_count is ignored.
//
// Parameters:
//   NOR_BURST_LEN - normal burst length in beats (must be < 2**LSIZE)
//   AXI_DSIZE     - AXI data width in bits (bytes per beat = AXI_DSIZE/8)
//   LSIZE         - width of the burst length field
//
// Ports:
//   clock       in   sole clock, rising edge
//   rst         in   asynchronous active-high reset
//   fsync       in   frame start pulse
//   frame_beats in   beats in the frame (sampled on accepted fsync)
//   base_addr   in   frame byte base address (sampled on accepted fsync)
//   fifo_count  in   beats available in the write-data FIFO
//   req_valid   out  burst request valid
//   req_ready   in   request accepted when high together with req_valid
//   req_addr    out  burst start byte address
//   req_len     out  burst length in beats
//   req_tail    out  request is the last burst of the frame
//   burst_done  in   one-cycle pulse: outstanding burst completed
//   busy        out  high whenever a frame is in progress
//   frame_done  out  one-cycle pulse when a frame completes
//   frame_err   out  one-cycle pulse when fsync arrives while busy
// ============================================================================
`timescale 1ns/1ps

module write_burst_scheduler #(
    parameter int NOR_BURST_LEN = 200,
    parameter int AXI_DSIZE     = 256,
    parameter int LSIZE         = 9
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             fsync,
    input  logic [31:0]      frame_beats,
    input  logic [31:0]      base_addr,
    input  logic [15:0]      fifo_count,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [31:0]      req_addr,
    output logic [LSIZE-1:0] req_len,
    output logic             req_tail,
    input  logic             burst_done,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err
);

    localparam int unsigned BPB      = AXI_DSIZE / 8;
    localparam logic [31:0] NOR_LEN_W = 32'(NOR_BURST_LEN);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        REQ       = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [31:0]        remaining_q;
    logic [31:0]        addr_q;
    logic [LSIZE-1:0]   len_q;
    logic               pending_q;
    logic [31:0]        pend_beats_q;
    logic [31:0]        pend_addr_q;
    logic               req_valid_q;
    logic [31:0]        req_addr_q;
    logic [LSIZE-1:0]   req_len_q;
    logic               req_tail_q;
    logic               frame_done_q;
    logic               frame_err_q;

    logic               restart_d;
    logic [31:0]        start_beats_d;
    logic [31:0]        start_addr_d;
    logic               err_d;
    logic               gate_ok;

    // Length of the next burst: a full burst, or whatever is left if less.
    function automatic logic [LSIZE-1:0] calcLen(input logic [31:0] rem);
        if (rem < NOR_LEN_W) begin
            return rem[LSIZE-1:0];
        end else begin
            return NOR_LEN_W[LSIZE-1:0];
        end
    endfunction

    // Decides whether the next request may leave WAIT_DATA.
`ifdef WR_SCHED_FIFO_GATE_EN
    assign gate_ok = ({16'd0, fifo_count} >= 32'(len_q));
`else
    logic unused_fifo;
    assign unused_fifo = ^fifo_count;
    assign gate_ok     = 1'b1;
`endif

    // Decides whether a (new) frame starts this cycle, and with which values.
    // A deferred fsync restarts on the burst_done of the outstanding burst. If
    // a fresh fsync coincides with that burst_done, the fresh one wins.
    always_comb begin
        restart_d     = 1'b0;
        start_beats_d = frame_beats;
        start_addr_d  = base_addr;
        err_d         = 1'b0;
        unique case (state_q)
            IDLE: begin
                restart_d = fsync;
            end
            WAIT_DATA: begin
                restart_d = fsync;
                err_d     = fsync;
            end
            REQ: begin
                err_d = fsync;
            end
            WAIT_DONE: begin
                err_d = fsync;
                if (burst_done) begin
                    if (fsync) begin
                        restart_d = 1'b1;
                    end else if (pending_q) begin
                        restart_d     = 1'b1;
                        start_beats_d = pend_beats_q;
                        start_addr_d  = pend_addr_q;
                    end
                end
            end
            default: begin
                restart_d = 1'b0;
            end
        endcase
    end

    // Main scheduler FSM. All outputs are registered here. req_valid is only
    // raised on entry to REQ, and frame_done only on a return to IDLE, so the
    // two can never be high in the same cycle.
    // A zero-beat frame finishes immediately with a frame_done pulse, including
    // when it was a deferred fsync that replaced an aborted frame.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            remaining_q  <= 32'd0;
            addr_q       <= 32'd0;
            len_q        <= '0;
            pending_q    <= 1'b0;
            pend_beats_q <= 32'd0;
            pend_addr_q  <= 32'd0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= 32'd0;
            req_len_q    <= '0;
            req_tail_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            frame_err_q  <= err_d;

            if (restart_d) begin
                remaining_q <= start_beats_d;
                addr_q      <= start_addr_d;
                pending_q   <= 1'b0;
                req_valid_q <= 1'b0;
                if (start_beats_d == 32'd0) begin
                    frame_done_q <= 1'b1;
                    state_q      <= IDLE;
                end else begin
                    len_q   <= calcLen(start_beats_d);
                    state_q <= WAIT_DATA;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        req_valid_q <= 1'b0;
                    end

                    WAIT_DATA: begin
                        if (gate_ok) begin
                            req_valid_q <= 1'b1;
                            req_addr_q  <= addr_q;
                            req_len_q   <= len_q;
                            req_tail_q  <= (32'(len_q) == remaining_q);
                            state_q     <= REQ;
                        end
                    end

                    REQ: begin
                        if (fsync) begin
                            pending_q    <= 1'b1;
                            pend_beats_q <= frame_beats;
                            pend_addr_q  <= base_addr;
                        end
                        if (req_ready) begin
                            req_valid_q <= 1'b0;
                            remaining_q <= remaining_q - 32'(len_q);
                            addr_q      <= addr_q + (32'(len_q) * BPB);
                            state_q     <= WAIT_DONE;
                        end
                    end

                    WAIT_DONE: begin
                        if (fsync) begin
                            pending_q    <= 1'b1;
                            pend_beats_q <= frame_beats;
                            pend_addr_q  <= base_addr;
                        end
                        if (burst_done) begin
                            if (remaining_q == 32'd0) begin
                                frame_done_q <= 1'b1;
                                state_q      <= IDLE;
                            end else begin
                                len_q   <= calcLen(remaining_q);
                                state_q <= WAIT_DATA;
                            end
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign req_valid  = req_valid_q;
    assign req_addr   = req_addr_q;
    assign req_len    = req_len_q;
    assign req_tail   = req_tail_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule
